// File: rtl/render_pkg.sv
// render_pkg
// Shared types and constants for the model fetch path.
//   tri_word_t    : one 64-bit triangle entry, exactly as stored in model RAM
//   camera_loc_t  : {theta[29:21], x[20:14], y[13:7], z[6:0]}
//   fetch_state_t : sequencer FSM states
//   RAM_READ_LAT  : cycles from address presented to data on ram_data_in
package render_pkg;

  localparam int RAM_READ_LAT = 2;

  typedef logic [63:0] tri_word_t;

  typedef struct packed {
    logic [8:0] theta;
    logic [6:0] x;
    logic [6:0] y;
    logic [6:0] z;
  } camera_loc_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

  // Bit 0 of a triangle entry is its enable flag.
  function automatic logic entry_enabled(input tri_word_t word);
    return word[0];
  endfunction

endpackage

// File: rtl/tri_fifo.sv
// tri_fifo
// Synchronous FIFO of triangle words with an occupancy count.
// Ports:
//   clk, rst       : clock, asynchronous active-low reset
//   push/push_data : write request and word
//   pop            : read request (ignored while empty)
//   head           : word at the read pointer (fall-through)
//   empty          : no words stored
//   count          : number of stored words, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module tri_fifo
  import render_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  tri_word_t              push_data,
  input  logic                   pop,
  output tri_word_t              head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTRW = $clog2(DEPTH);

  tri_word_t       mem [DEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic            full;
  logic            do_push;
  logic            do_pop;

  assign empty = (count == '0);
  assign full  = (count == (PTRW+1)'(DEPTH));
  assign head  = mem[rd_ptr];

  // A push into a full FIFO is only legal when a pop frees the slot in the
  // same cycle; the overwritten slot is the one being read out.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the sequencer masks head while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/model_fetch_sequencer.sv
// model_fetch_sequencer
// Streams the triangle entries of the model RAM, in address order, to the
// projection pipeline once per frame_start_in, buffering RAM returns in a
// small FIFO so that downstream back-pressure never loses a word.
// Ports:
//   clk, rst         : clock, asynchronous active-low reset
//   frame_start_in   : pulse requesting a pass (ignored while busy)
//   camera_loc_in    : camera location, latched when a pass is accepted
//   addr_out         : model RAM read address
//   ram_data_in      : model RAM data, RAM_READ_LAT cycles after addr_out
//   tri_valid_out/tri_ready_in/tri_data_out : triangle stream handshake
//   camera_loc_out   : camera location of the current/last pass
//   busy_out         : pass in progress
//   frame_done_out   : one-cycle pulse at the end of a pass
// Build option: define FETCH_SKIP_DISABLED_EN to drop entries whose bit 0
// is clear instead of delivering them (they are still read).
module model_fetch_sequencer
  import render_pkg::*;
#(
  parameter int SIZE       = 4,
  parameter int ADDRW      = $clog2(SIZE),
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start_in,
  input  logic [29:0]      camera_loc_in,
  output logic [ADDRW-1:0] addr_out,
  input  logic [63:0]      ram_data_in,
  output logic             tri_valid_out,
  input  logic             tri_ready_in,
  output logic [63:0]      tri_data_out,
  output logic [29:0]      camera_loc_out,
  output logic             busy_out,
  output logic             frame_done_out
);

  localparam int               CNTW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(SIZE - 1);

  fetch_state_t            state;
  fetch_state_t            state_next;
  camera_loc_t             camera_q;
  logic [RAM_READ_LAT-1:0] read_pipe;
  logic [CNTW-1:0]         reads_in_flight;
  logic [CNTW:0]           outstanding;
  logic [CNTW-1:0]         fifo_count;
  logic                    fifo_empty;
  logic                    fifo_push;
  logic                    fifo_pop;
  tri_word_t               fifo_head;
  logic                    room;
  logic                    accept;
  logic                    issue;

  assign camera_loc_out = camera_q;

  // read_pipe[i] marks a read issued i+1 cycles ago; the oldest stage lines
  // up with its data on ram_data_in.
  always_comb begin
    reads_in_flight = '0;
    for (int i = 0; i < RAM_READ_LAT; i++) begin
      reads_in_flight = reads_in_flight + CNTW'(read_pipe[i]);
    end
    outstanding = {1'b0, reads_in_flight} + {1'b0, fifo_count};
    room        = outstanding < (CNTW+1)'(FIFO_DEPTH);
  end

`ifdef FETCH_SKIP_DISABLED_EN
  assign fifo_push = read_pipe[RAM_READ_LAT-1] && entry_enabled(ram_data_in);
`else
  assign fifo_push = read_pipe[RAM_READ_LAT-1];
`endif

  assign tri_valid_out = !fifo_empty;
  assign fifo_pop      = tri_valid_out && tri_ready_in;
  assign tri_data_out  = fifo_empty ? '0 : fifo_head;

  tri_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_data(ram_data_in),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Reads are only issued while every outstanding word (in flight or
  // buffered) is guaranteed a FIFO slot, so back-pressure can never
  // overflow the buffer.
  always_comb begin
    state_next     = state;
    accept         = 1'b0;
    issue          = 1'b0;
    busy_out       = 1'b1;
    frame_done_out = 1'b0;
    case (state)
      IDLE: begin
        busy_out = 1'b0;
        if (frame_start_in) begin
          accept     = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (room) begin
          issue = 1'b1;
          if (addr_out == LAST_ADDR) state_next = DRAIN;
        end
      end
      DRAIN: begin
        // A pending handshake implies a non-empty FIFO; it is kept explicit
        // so the exit condition reads as the full set of quiet conditions.
        if ((reads_in_flight == '0) && fifo_empty &&
            !(tri_valid_out && !tri_ready_in)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        frame_done_out = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Address and camera registers; the address stops at the last entry rather
  // than wrapping so it holds when no further reads are issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_out  <= '0;
      camera_q  <= '0;
      read_pipe <= '0;
    end else begin
      read_pipe <= {read_pipe[RAM_READ_LAT-2:0], issue};
      if (accept) begin
        addr_out <= '0;
        camera_q <= camera_loc_t'(camera_loc_in);
      end else if (issue && (addr_out != LAST_ADDR)) begin
        addr_out <= addr_out + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_model_fetch_sequencer.sv
// tb_model_fetch_sequencer
// Directed passes on a SIZE=4 instance (latency, back-pressure, ignored
// restart, mid-pass reset, enable-bit handling) and randomized back-pressure
// passes on a SIZE=16 instance, each against a RAM model and an expected
// word list built from the RAM contents.
module tb_model_fetch_sequencer;

  localparam int SMALL = 4;
  localparam int BIG   = 16;

  typedef struct {
    int          cyc;
    logic [63:0] data;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  int          cyc = 0;
  int          compared = 0;
  int          mismatched = 0;

  logic        start4, ready4, valid4, busy4, done4;
  logic [29:0] cam4, camout4;
  logic [1:0]  addr4;
  logic [63:0] rdata4, data4, r4_s1;
  logic [63:0] ram4 [SMALL];

  logic        start16, ready16, valid16, busy16, done16;
  logic [29:0] cam16, camout16;
  logic [3:0]  addr16;
  logic [63:0] rdata16, data16, r16_s1;
  logic [63:0] ram16 [BIG];

  beat_t       seen4 [$];
  logic [63:0] seen16 [$];
  logic [63:0] exp_q [$];
  logic        hold4 = 1'b0, hold16 = 1'b0;
  logic [63:0] held4 = '0, held16 = '0;

  model_fetch_sequencer #(.SIZE(SMALL)) dut4 (
    .clk(clk), .rst(rst), .frame_start_in(start4), .camera_loc_in(cam4),
    .addr_out(addr4), .ram_data_in(rdata4), .tri_valid_out(valid4),
    .tri_ready_in(ready4), .tri_data_out(data4), .camera_loc_out(camout4),
    .busy_out(busy4), .frame_done_out(done4)
  );

  model_fetch_sequencer #(.SIZE(BIG)) dut16 (
    .clk(clk), .rst(rst), .frame_start_in(start16), .camera_loc_in(cam16),
    .addr_out(addr16), .ram_data_in(rdata16), .tri_valid_out(valid16),
    .tri_ready_in(ready16), .tri_data_out(data16), .camera_loc_out(camout16),
    .busy_out(busy16), .frame_done_out(done16)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Two-stage model RAMs: address sampled, then output register.
  always @(posedge clk) begin
    r4_s1   <= ram4[addr4];
    rdata4  <= r4_s1;
    r16_s1  <= ram16[addr16];
    rdata16 <= r16_s1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Monitors: record accepted words and check that a stalled word holds.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      hold4  <= 1'b0;
      hold16 <= 1'b0;
    end else begin
      if (hold4) begin
        checkOutput("hold_valid4", 64'(valid4), 64'd1);
        checkOutput("hold_data4", data4, held4);
      end
      if (hold16) begin
        checkOutput("hold_valid16", 64'(valid16), 64'd1);
        checkOutput("hold_data16", data16, held16);
      end
      if (valid4 && ready4) seen4.push_back('{cyc: cyc, data: data4});
      if (valid16 && ready16) seen16.push_back(data16);
      hold4  <= valid4 && !ready4;
      held4  <= data4;
      hold16 <= valid16 && !ready16;
      held16 <= data16;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit big, input logic [29:0] cam, output int s);
    tick();
    if (big) begin start16 = 1'b1; cam16 = cam; end
    else     begin start4  = 1'b1; cam4  = cam; end
    s = cyc;
    tick();
    start4  = 1'b0;
    start16 = 1'b0;
  endtask

  task automatic waitDone(input int budget, output int done_at);
    done_at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done4 === 1'b1) begin
        done_at = cyc;
        break;
      end
    end
  endtask

  task automatic fillSmall();
    for (int i = 0; i < SMALL; i++) ram4[i] = {$urandom(), $urandom()} | 64'd1;
  endtask

  initial begin
    int          s, d, dones;
    logic [29:0] cam;

    rst = 1'b0; start4 = 1'b0; ready4 = 1'b1; cam4 = '0;
    start16 = 1'b0; ready16 = 1'b1; cam16 = '0;
    fillSmall();
    for (int i = 0; i < BIG; i++) ram16[i] = {$urandom(), $urandom()};
    repeat (3) tick();
    @(negedge clk);
    checkOutput("rst_valid", 64'(valid4), 64'd0);
    checkOutput("rst_done", 64'(done4), 64'd0);
    checkOutput("rst_busy", 64'(busy4), 64'd0);
    checkOutput("rst_addr", 64'(addr4), 64'd0);
    checkOutput("rst_cam", 64'(camout4), 64'd0);
    checkOutput("rst_data", data4, 64'd0);
    checkOutput("rst_valid16", 64'(valid16), 64'd0);
    tick();
    rst = 1'b1;
    repeat (2) tick();

    // Free-running pass: words on cycles s+4..s+7, done on s+9.
    $display("[TB] pass with ready held high");
    fillSmall();
    seen4.delete();
    cam = 30'($urandom());
    applyStimulus(0, cam, s);
    @(negedge clk);
    checkOutput("busy_in_pass", 64'(busy4), 64'd1);
    checkOutput("cam_latched", 64'(camout4), 64'(cam));
    waitDone(40, d);
    checkOutput("done_cycle", 64'(d), 64'(s + 9));
    checkOutput("beat_count", 64'(seen4.size()), 64'(SMALL));
    for (int i = 0; i < seen4.size() && i < SMALL; i++) begin
      checkOutput("beat_data", seen4[i].data, ram4[i]);
      checkOutput("beat_cycle", 64'(seen4[i].cyc), 64'(s + 4 + i));
    end
    tick();
    @(negedge clk);
    checkOutput("idle_busy", 64'(busy4), 64'd0);
    checkOutput("done_pulse_width", 64'(done4), 64'd0);

    // Back-pressure: ready low on cycles s+3..s+12.
    $display("[TB] pass with ready stalled");
    fillSmall();
    seen4.delete();
    applyStimulus(0, 30'($urandom()), s);
    d = -1;
    for (int k = 1; k <= 30; k++) begin
      ready4 = !(k >= 3 && k <= 12);
      @(negedge clk);
      if (k == 8) begin
        checkOutput("stall_valid", 64'(valid4), 64'd1);
        checkOutput("stall_data", data4, ram4[0]);
      end
      if (k == 12) checkOutput("stall_addr", 64'(addr4), 64'(SMALL - 1));
      if (done4 === 1'b1 && d < 0) d = cyc;
      tick();
    end
    ready4 = 1'b1;
    checkOutput("stall_count", 64'(seen4.size()), 64'(SMALL));
    for (int i = 0; i < seen4.size() && i < SMALL; i++)
      checkOutput("stall_order", seen4[i].data, ram4[i]);
    if (seen4.size() > 0) checkOutput("stall_first_cycle", 64'(seen4[0].cyc), 64'(s + 13));
    checkOutput("stall_done_cycle", 64'(d), 64'(s + 18));

    // Restart request while busy is ignored.
    $display("[TB] restart request during a pass");
    fillSmall();
    seen4.delete();
    cam = 30'($urandom());
    if (cam == 30'h1234567) cam = cam ^ 30'd1;
    applyStimulus(0, cam, s);
    tick();
    tick();
    start4 = 1'b1;
    cam4   = 30'h1234567;
    tick();
    start4 = 1'b0;
    @(negedge clk);
    checkOutput("restart_cam_mid", 64'(camout4), 64'(cam));
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done4 === 1'b1) dones++;
    end
    checkOutput("restart_dones", 64'(dones), 64'd1);
    checkOutput("restart_count", 64'(seen4.size()), 64'(SMALL));
    checkOutput("restart_cam_end", 64'(camout4), 64'(cam));

    // Reset in cycle s+5 of a pass, then a clean pass.
    $display("[TB] reset in the middle of a pass");
    fillSmall();
    applyStimulus(0, 30'($urandom()), s);
    repeat (4) tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    checkOutput("mid_rst_valid", 64'(valid4), 64'd0);
    checkOutput("mid_rst_done", 64'(done4), 64'd0);
    checkOutput("mid_rst_busy", 64'(busy4), 64'd0);
    checkOutput("mid_rst_addr", 64'(addr4), 64'd0);
    checkOutput("mid_rst_cam", 64'(camout4), 64'd0);
    checkOutput("mid_rst_data", data4, 64'd0);
    tick();
    rst = 1'b1;
    seen4.delete();
    repeat (3) tick();
    fillSmall();
    applyStimulus(0, 30'($urandom()), s);
    waitDone(40, d);
    checkOutput("post_rst_done", 64'(d), 64'(s + 9));
    checkOutput("post_rst_count", 64'(seen4.size()), 64'(SMALL));
    for (int i = 0; i < seen4.size() && i < SMALL; i++)
      checkOutput("post_rst_data", seen4[i].data, ram4[i]);

    // Entry 1 with its enable bit clear.
    $display("[TB] pass with a disabled entry");
    fillSmall();
    ram4[1] = ram4[1] & ~64'd1;
    exp_q.delete();
    for (int i = 0; i < SMALL; i++) begin
`ifdef FETCH_SKIP_DISABLED_EN
      if (ram4[i][0]) exp_q.push_back(ram4[i]);
`else
      exp_q.push_back(ram4[i]);
`endif
    end
    seen4.delete();
    applyStimulus(0, 30'($urandom()), s);
    waitDone(40, d);
    checkOutput("skip_done", 64'(d), 64'(s + 9));
    checkOutput("skip_count", 64'(seen4.size()), 64'(exp_q.size()));
    for (int i = 0; i < seen4.size() && i < exp_q.size(); i++)
      checkOutput("skip_data", seen4[i].data, exp_q[i]);

    // Random back-pressure (about 30% low) on the 16-entry instance.
    $display("[TB] random back-pressure passes");
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < BIG; i++) ram16[i] = {$urandom(), $urandom()};
      exp_q.delete();
      for (int i = 0; i < BIG; i++) begin
`ifdef FETCH_SKIP_DISABLED_EN
        if (ram16[i][0]) exp_q.push_back(ram16[i]);
`else
        exp_q.push_back(ram16[i]);
`endif
      end
      seen16.delete();
      cam = 30'($urandom());
      applyStimulus(1, cam, s);
      d = -1;
      for (int k = 0; k < 400; k++) begin
        ready16 = ($urandom_range(9) >= 3);
        @(negedge clk);
        if (done16 === 1'b1) begin
          d = cyc;
          break;
        end
        tick();
      end
      ready16 = 1'b1;
      checkOutput("rand_done_seen", 64'(d >= 0), 64'd1);
      checkOutput("rand_count", 64'(seen16.size()), 64'(exp_q.size()));
      for (int i = 0; i < seen16.size() && i < exp_q.size(); i++)
        checkOutput("rand_data", seen16[i], exp_q[i]);
      checkOutput("rand_cam", 64'(camout16), 64'(cam));
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/model_fetch_sequencer.md
MODEL_FETCH_SEQUENCER -- requirements
Module: model_fetch_sequencer

Interface
REQ-001 SHALL have parameter SIZE, default 4: number of triangle entries in the model RAM.
REQ-002 SHALL have parameter ADDRW, default $clog2(SIZE): model RAM address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: output buffer entries; power of two, at least 4.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 frame_start_in  input  1  one-cycle pulse requesting a model pass.
REQ-007 camera_loc_in  input  30  {theta[29:21], x[20:14], y[13:7], z[6:0]}; sampled on an accepted frame_start_in.
REQ-008 addr_out  output  ADDRW  model RAM read address.
REQ-009 ram_data_in  input  64  model RAM douta; fixed 2-cycle read latency, output register always enabled.
REQ-010 tri_valid_out  output  1  triangle word valid to the projection pipeline.
REQ-011 tri_ready_in  input  1  projection pipeline accepts the word.
REQ-012 tri_data_out  output  64  triangle word, bit-exact copy of the RAM entry.
REQ-013 camera_loc_out  output  30  latched camera location, stable for the whole pass.
REQ-014 busy_out  output  1  high from an accepted frame_start_in until frame_done_out.
REQ-015 frame_done_out  output  1  one-cycle pulse at pass completion.

Function
REQ-016 SHALL implement an FSM with states IDLE, FETCH, DRAIN, DONE.
REQ-017 IDLE: frame_start_in=1 -> FETCH; latch camera_loc_in; reset the read pointer to 0.
REQ-018 FETCH: issue one read per cycle, addr_out=0..SIZE-1 ascending, only while (reads in flight + FIFO occupancy) < FIFO_DEPTH.
REQ-019 Each issued read SHALL push ram_data_in into the FIFO exactly 2 cycles after issue; no RAM word SHALL be dropped.
REQ-020 FETCH -> DRAIN on the cycle after address SIZE-1 is issued.
REQ-021 DRAIN -> DONE when no reads are in flight, the FIFO is empty, and no handshake is pending.
REQ-022 DONE: assert frame_done_out for one cycle, then go to IDLE.
REQ-023 The valid/ready handshake completes on a cycle with tri_valid_out=1 and tri_ready_in=1; tri_valid_out=1 whenever the FIFO is non-empty.
REQ-024 While tri_valid_out=1 and tri_ready_in=0, tri_data_out SHALL hold stable.
REQ-025 Latency: with tri_ready_in held high, the first tri_valid_out SHALL occur 4 cycles after the accepted frame_start_in; throughput SHALL be 1 triangle per cycle.
REQ-026 frame_start_in while busy_out=1 SHALL be ignored; camera_loc_out SHALL NOT change.
REQ-027 A simultaneous FIFO push and pop SHALL leave occupancy unchanged.
REQ-028 Triangles SHALL be delivered in address order.
REQ-029 addr_out SHALL hold its last value when no read is issued.

Reset
REQ-030 Reset values: tri_valid_out=0, frame_done_out=0, busy_out=0, addr_out=0, camera_loc_out=0, tri_data_out=0.
REQ-031 Reset values: state=IDLE, FIFO empty, in-flight count=0.
REQ-032 Reset mid-pass SHALL discard all in-flight reads and buffered triangles; RAM returns arriving after reset release SHALL be ignored.

Configuration
REQ-033 Macro FETCH_SKIP_DISABLED_EN: when defined, entries with bit[0]=0 SHALL NOT be pushed into the FIFO; their addresses are still read and counted.
REQ-034 Without FETCH_SKIP_DISABLED_EN, every entry SHALL be delivered regardless of bit[0].

Structure
REQ-035 Package render_pkg SHALL hold the triangle word typedef, the camera_loc field typedef, the FSM state enum, and the constant RAM_READ_LAT=2.
REQ-036 Sub-module tri_fifo (synchronous FIFO, FIFO_DEPTH x 64, with occupancy count) SHALL implement the buffering.

Verification
REQ-037 SIZE=4, ready held high, pulse at cycle 0 -> 4 words A0..A3 on cycles 4..7; frame_done_out pulses on cycle 9.
REQ-038 Ready low for cycles 3..12 -> addr_out stops at 3; tri_data_out holds A0; no loss; order A0..A3 preserved.
REQ-039 frame_start_in pulsed with camera 0x1234567 during a pass -> ignored; camera_loc_out keeps the first value; one frame_done_out.
REQ-040 rst asserted in cycle 5 of a pass -> all outputs at reset values next cycle; a new pass after release delivers exactly SIZE words.
REQ-041 FETCH_SKIP_DISABLED_EN defined, entry1 bit0=0 -> only A0, A2, A3 delivered; frame_done_out still pulses.
REQ-042 Random ready with 30% low, SIZE=16 -> scoreboard matches all 16 entries in order; FIFO never overflows.
